// File: rtl/gg_pcm_pkg.sv
// gg_pcm_pkg: shared constants and beat/rotation mapping for the PCM reorder buffer
package gg_pcm_pkg;
    localparam int NB_MONO = 16;
    localparam int NB_420 = 24;
    typedef enum logic {FMT_MONO = 1'b0, FMT_420 = 1'b1} chroma_fmt_e;
    function automatic logic [6:0] wr_map(input logic [4:0] blk, input logic [1:0] row);
        return blk[4] ? {2'b10, blk[2], blk[1], row[1], row[0], blk[0]}
                      : {1'b0, blk[3], blk[1], row, blk[2], blk[0]};
    endfunction
    function automatic logic [1:0] sram_sel(input logic [1:0] beat_lo, input logic [1:0] pos);
        return pos + beat_lo;
    endfunction
    function automatic logic [1:0] rd_pos(input logic [1:0] sram, input logic [1:0] beat_lo);
        return sram - beat_lo;
    endfunction
endpackage

// File: rtl/gg_pcm_skid.sv
// gg_pcm_skid: 2-entry fall-through skid register between SRAM read data and the output port
module gg_pcm_skid #(
    parameter int W = 129
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_cnt
);
    logic [W-1:0] r_mem [2];
    logic         r_head;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;
    assign w_pop = (r_cnt != 2'd0) && i_ready;
    assign w_push = i_valid && !((r_cnt == 2'd0) && i_ready);
    assign o_valid = (r_cnt != 2'd0) || i_valid;
    assign o_data = (r_cnt != 2'd0) ? r_mem[r_head] : i_data;
    assign o_cnt = r_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            r_head <= r_head ^ w_pop;
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_head ^ r_cnt[0]] <= i_data;
    end
endmodule

// File: rtl/gg_sram_1r1w.sv
// gg_sram_1r1w: simple dual-port SRAM with one-cycle registered read
module gg_sram_1r1w #(
    parameter int WIDTH = 32,
    parameter int WORDS = 64,
    parameter int ADDR = 6
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [ADDR-1:0]  i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [ADDR-1:0]  i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [WORDS];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/gg_pcm_ring_buf.sv
// gg_pcm_ring_buf: multi-slot reorder buffer turning 4x4 encode-order blocks into PCM raster beats
module gg_pcm_ring_buf
    import gg_pcm_pkg::*;
#(
    parameter int BANKS = 2,
    parameter int CHROMA_FMT = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [127:0]                 s_data,
    input  logic                         s_last,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [127:0]                 m_data,
    output logic                         m_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(BANKS+1)-1:0]   level,
    output logic                         err
);
    localparam chroma_fmt_e FMT = chroma_fmt_e'(CHROMA_FMT[0]);
    localparam int NB = (FMT == FMT_420) ? NB_420 : NB_MONO;
    localparam int ADDR = $clog2(BANKS * 32);
    localparam int SW = ADDR - 5;
    localparam int CW = $clog2(BANKS + 1);
    localparam logic [4:0] LAST_BEAT = 5'(NB - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(BANKS - 1);
    localparam logic [CW-1:0] FULL = CW'(BANKS);
    logic [SW-1:0]   r_wptr;
    logic [SW-1:0]   r_rptr;
    logic [4:0]      r_wcnt;
    logic [4:0]      r_rcnt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_icnt;
    logic            r_err;
    logic            r_rd_v;
    logic            r_rd_last;
    logic [1:0]      r_rd_lo;
    logic            w_acc;
    logic            w_wlast;
    logic            w_commit;
    logic            w_rlast;
    logic            w_room;
    logic            w_issue;
    logic            w_release;
    logic [6:0]      w_map [4];
    logic [31:0]     w_wdata [4];
    logic [ADDR-1:0] w_waddr [4];
    logic [31:0]     w_rdata [4];
    logic [127:0]    w_rd_data;
    logic            w_sk_valid;
    logic [128:0]    w_sk_data;
    logic [1:0]      w_sk_cnt;
    assign s_ready = !reset && (r_cnt < FULL);
    assign level = reset ? '0 : r_cnt;
    assign err = !reset && r_err;
    assign w_acc = s_valid && s_ready;
    assign w_wlast = r_wcnt == LAST_BEAT;
    assign w_commit = w_acc && w_wlast;
    assign w_rlast = r_rcnt == LAST_BEAT;
    assign w_room = (w_sk_cnt == 2'd0) || ((w_sk_cnt == 2'd1) && !r_rd_v);
    assign w_issue = (r_icnt != '0) && w_room;
    assign w_release = m_valid && m_ready && m_last;
    assign m_valid = !reset && w_sk_valid;
    assign m_data = m_valid ? w_sk_data[127:0] : '0;
    assign m_last = m_valid && w_sk_data[128];
    always_comb begin
        for (int r = 0; r < 4; r++) w_map[r] = wr_map(r_wcnt, 2'(r));
    end
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_wdata[j] = '0;
            w_waddr[j] = '0;
            for (int r = 0; r < 4; r++) begin
                if (sram_sel(w_map[r][3:2], w_map[r][1:0]) == 2'(j)) begin
                    w_wdata[j] = s_data[32*r +: 32];
                    w_waddr[j] = {r_wptr, w_map[r][6:2]};
                end
            end
        end
    end
    always_comb begin
        w_rd_data = '0;
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 4; j++)
                if (rd_pos(2'(j), r_rd_lo) == 2'(p)) w_rd_data[32*p +: 32] = w_rdata[j];
    end
    for (genvar g = 0; g < 4; g++) begin : g_sram
        gg_sram_1r1w #(.WIDTH(32), .WORDS(BANKS * 32), .ADDR(ADDR)) u_sram (
            .clk     (clk),
            .i_we    (w_acc),
            .i_waddr (w_waddr[g]),
            .i_wdata (w_wdata[g]),
            .i_re    (w_issue),
            .i_raddr ({r_rptr, r_rcnt}),
            .o_rdata (w_rdata[g])
        );
    end
    gg_pcm_skid #(.W(129)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_rd_v),
        .i_data  ({r_rd_last, w_rd_data}),
        .i_ready (m_ready),
        .o_valid (w_sk_valid),
        .o_data  (w_sk_data),
        .o_cnt   (w_sk_cnt)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_wcnt <= '0;
            r_rcnt <= '0;
            r_cnt <= '0;
            r_icnt <= '0;
            r_err <= 1'b0;
            r_rd_v <= 1'b0;
            r_rd_last <= 1'b0;
            r_rd_lo <= '0;
        end else begin
            if (w_acc) begin
                r_wcnt <= w_wlast ? '0 : r_wcnt + 5'd1;
                if (w_wlast) r_wptr <= (r_wptr == LAST_SLOT) ? '0 : r_wptr + SW'(1);
                if (s_last != w_wlast) r_err <= 1'b1;
            end
            if (w_issue) begin
                r_rcnt <= w_rlast ? '0 : r_rcnt + 5'd1;
                if (w_rlast) r_rptr <= (r_rptr == LAST_SLOT) ? '0 : r_rptr + SW'(1);
            end
            r_rd_v <= w_issue;
            r_rd_last <= w_rlast;
            r_rd_lo <= r_rcnt[1:0];
            r_cnt <= r_cnt + CW'(w_commit) - CW'(w_release);
            r_icnt <= r_icnt + CW'(w_commit) - CW'(w_issue && w_rlast);
        end
    end
endmodule

// File: tb/tb_gg_pcm_ring_buf.sv
// tb_gg_pcm_ring_buf: image-level reference model checking 4:2:0 (3 slots) and monochrome (2 slots) buffers
module tb_gg_pcm_ring_buf;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sel = 1'b0;
    logic [127:0] s_data = '0;
    logic s_last = 1'b0;
    logic s_valid = 1'b0;
    logic m_ready = 1'b0;
    logic s_valid_c, s_valid_m;
    logic s_ready_c, s_ready_m, m_last_c, m_last_m, m_valid_c, m_valid_m, err_c, err_m;
    logic [127:0] m_data_c, m_data_m;
    logic [1:0] level_c, level_m;
    logic s_ready_x, m_valid_x, m_last_x, err_x;
    logic [127:0] m_data_x;
    logic [1:0] level_x;
    int ntests = 0;
    int nfail = 0;
    logic [128:0] in_q[$];
    logic [128:0] exp_q[$];
    int p_in = 100;
    int p_out = 100;
    int cyc = 0;
    int acc = 0;
    int last_in = 0;
    int first_out = 0;
    bit seen_out = 1'b0;
    logic [127:0] first_data = '0;
    bit stall = 1'b0;
    logic [128:0] prev = '0;
    bit out_last_fire = 1'b0;
    logic smp_s_ready = 1'b0;
    logic smp_err = 1'b0;
    logic [1:0] smp_level = '0;

    always #5 clk = ~clk;

    assign s_valid_c = s_valid && !sel;
    assign s_valid_m = s_valid && sel;
    assign s_ready_x = sel ? s_ready_m : s_ready_c;
    assign m_valid_x = sel ? m_valid_m : m_valid_c;
    assign m_last_x = sel ? m_last_m : m_last_c;
    assign m_data_x = sel ? m_data_m : m_data_c;
    assign level_x = sel ? level_m : level_c;
    assign err_x = sel ? err_m : err_c;

    gg_pcm_ring_buf #(.BANKS(3), .CHROMA_FMT(1)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_last(s_last), .s_valid(s_valid_c),
        .s_ready(s_ready_c), .m_data(m_data_c), .m_last(m_last_c), .m_valid(m_valid_c),
        .m_ready(m_ready), .level(level_c), .err(err_c));

    gg_pcm_ring_buf #(.BANKS(2), .CHROMA_FMT(0)) dut_m (
        .clk(clk), .reset(reset), .s_data(s_data), .s_last(s_last), .s_valid(s_valid_m),
        .s_ready(s_ready_m), .m_data(m_data_m), .m_last(m_last_m), .m_valid(m_valid_m),
        .m_ready(m_ready), .level(level_m), .err(err_m));

    task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Build one macroblock as images, then derive encode-order blocks and raster-order beats.
    task automatic make_mb(input int nb, input bit pat, input int bad);
        logic [7:0] y [16][16];
        logic [7:0] cb [8][8];
        logic [7:0] cr [8][8];
        logic [127:0] d;
        int bx, by, k;
        for (int yy = 0; yy < 16; yy++)
            for (int xx = 0; xx < 16; xx++)
                y[yy][xx] = pat ? 8'((yy / 8) * 8 + (xx / 8) * 4 + ((yy / 4) % 2) * 2 + (xx / 4) % 2) : 8'($urandom);
        for (int yy = 0; yy < 8; yy++)
            for (int xx = 0; xx < 8; xx++) begin
                cb[yy][xx] = pat ? 8'(128 + (yy / 4) * 2 + xx / 4) : 8'($urandom);
                cr[yy][xx] = pat ? 8'(132 + (yy / 4) * 2 + xx / 4) : 8'($urandom);
            end
        for (int b = 0; b < nb; b++) begin
            d = '0;
            if (b < 16) begin
                bx = ((b >> 2) & 1) * 2 + (b & 1);
                by = ((b >> 3) & 1) * 2 + ((b >> 1) & 1);
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) d[32*r + 8*c +: 8] = y[4*by + r][4*bx + c];
            end else begin
                k = b - 16;
                bx = k % 2;
                by = (k % 4) / 2;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        d[32*r + 8*c +: 8] = (k < 4) ? cb[4*by + r][4*bx + c] : cr[4*by + r][4*bx + c];
            end
            in_q.push_back({(b == nb - 1) || (b == bad), d});
        end
        for (int yy = 0; yy < 16; yy++) begin
            for (int xx = 0; xx < 16; xx++) d[8*xx +: 8] = y[yy][xx];
            exp_q.push_back({(nb == 16) && (yy == 15), d});
        end
        if (nb == 24)
            for (int pl = 0; pl < 2; pl++)
                for (int kk = 0; kk < 4; kk++) begin
                    for (int xx = 0; xx < 8; xx++) begin
                        d[8*xx +: 8] = pl ? cr[2*kk][xx] : cb[2*kk][xx];
                        d[64 + 8*xx +: 8] = pl ? cr[2*kk + 1][xx] : cb[2*kk + 1][xx];
                    end
                    exp_q.push_back({(pl == 1) && (kk == 3), d});
                end
    endtask

    task automatic tick();
        @(negedge clk);
        s_valid = (in_q.size() != 0) && (int'($urandom_range(99)) < p_in);
        if (s_valid) {s_last, s_data} = in_q[0];
        else {s_last, s_data} = '0;
        m_ready = int'($urandom_range(99)) < p_out;
        #1;
        smp_s_ready = s_ready_x;
        smp_level = level_x;
        smp_err = err_x;
        if (stall) chk("stall", 130'({m_valid_x, m_last_x, m_data_x}), 130'({1'b1, prev}));
        if (m_valid_x) begin
            if (!seen_out) begin
                seen_out = 1'b1;
                first_out = cyc;
                first_data = m_data_x;
            end
            chk("beat_expected", 130'(exp_q.size() != 0), 130'(1));
            if (exp_q.size() != 0) begin
                chk("beat", 130'({m_last_x, m_data_x}), 130'(exp_q[0]));
                if (m_ready) void'(exp_q.pop_front());
            end
        end
        out_last_fire = m_valid_x && m_ready && m_last_x;
        stall = m_valid_x && !m_ready;
        prev = {m_last_x, m_data_x};
        if (s_valid && s_ready_x) begin
            if (s_last) last_in = cyc;
            void'(in_q.pop_front());
            acc++;
        end
        cyc++;
    endtask

    task automatic run_drain(input int bound);
        int n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        chk("drain", 130'(in_q.size() + exp_q.size()), 130'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        chk("rst_s_ready", 130'(s_ready_x), 130'(0));
        chk("rst_m_valid", 130'(m_valid_x), 130'(0));
        chk("rst_m_last", 130'(m_last_x), 130'(0));
        chk("rst_m_data", 130'(m_data_x), 130'(0));
        chk("rst_level", 130'(level_x), 130'(0));
        chk("rst_err", 130'(err_x), 130'(0));
        @(negedge clk);
        reset = 1'b0;
        in_q.delete();
        exp_q.delete();
        stall = 1'b0;
        #1;
        chk("post_rst_m_valid", 130'(m_valid_x), 130'(0));
        chk("post_rst_level", 130'(level_x), 130'(0));
        chk("post_rst_err", 130'(err_x), 130'(0));
        chk("post_rst_s_ready", 130'(s_ready_x), 130'(1));
    endtask

    initial begin
        int n;
        int a0;
        do_reset();
        // patterned macroblock: latency and first-beat layout
        seen_out = 1'b0;
        make_mb(24, 1'b1, -1);
        run_drain(500);
        chk("latency", 130'(first_out - last_in), 130'(2));
        chk("beat0", 130'(first_data), 130'(128'h05050505_04040404_01010101_00000000));
        // fill all three slots with the output blocked
        p_out = 0;
        repeat (3) make_mb(24, 1'b0, -1);
        n = 0;
        while (in_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("fill_level", 130'(smp_level), 130'(3));
        chk("fill_s_ready", 130'(smp_s_ready), 130'(0));
        p_out = 100;
        out_last_fire = 1'b0;
        n = 0;
        while (!out_last_fire && n < 100) begin
            tick();
            n++;
        end
        chk("release_seen", 130'(out_last_fire), 130'(1));
        p_out = 0;
        tick();
        chk("release_s_ready", 130'(smp_s_ready), 130'(1));
        chk("release_level", 130'(smp_level), 130'(2));
        p_out = 100;
        run_drain(500);
        // random traffic on both sides
        p_in = 70;
        p_out = 60;
        repeat (50) make_mb(24, 1'b0, -1);
        run_drain(20000);
        // early s_last on beat 10
        p_in = 100;
        p_out = 100;
        tick();
        chk("err_before", 130'(smp_err), 130'(0));
        make_mb(24, 1'b0, 10);
        a0 = acc;
        n = 0;
        while (acc < a0 + 11 && n < 100) begin
            tick();
            n++;
        end
        tick();
        chk("err_set", 130'(smp_err), 130'(1));
        run_drain(500);
        tick();
        chk("err_sticky", 130'(smp_err), 130'(1));
        // reset with one full slot and one partial slot
        p_out = 0;
        make_mb(24, 1'b0, -1);
        make_mb(24, 1'b0, -1);
        a0 = acc;
        n = 0;
        while (acc < a0 + 36 && n < 200) begin
            tick();
            n++;
        end
        tick();
        chk("mid_level", 130'(smp_level), 130'(1));
        chk("mid_err", 130'(smp_err), 130'(1));
        do_reset();
        p_out = 100;
        make_mb(24, 1'b0, -1);
        run_drain(500);
        // monochrome instance
        sel = 1'b1;
        do_reset();
        p_in = 80;
        p_out = 70;
        repeat (3) make_mb(16, 1'b0, -1);
        run_drain(2000);
        p_out = 100;
        repeat (20) tick();
        chk("mono_idle_level", 130'(smp_level), 130'(0));
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
